// File: rtl/aes_dom_inverse_seq.sv
// Sequencer and randomness distributor for the 3-share DOM GF(2^8) inverter.
// Tracks slot occupancy, pulses stage enables and delays each randomness slice to its stage.
module aes_dom_inverse_seq #(
    parameter int unsigned RndWidth = 102
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                rnd_valid_i,
    input  logic [RndWidth-1:0] rnd_i,
    output logic                rnd_ready_o,
    output logic [3:0]          we_o,
    output logic [23:0]         prd_stage1_o,
    output logic [17:0]         prd_stage2_o,
    output logic [9:0]          prd_stage3a_o,
    output logic [9:0]          prd_stage3b_o,
    output logic [19:0]         prd_stage4a_o,
    output logic [19:0]         prd_stage4b_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o
);

    localparam int unsigned NumStages = 4;
    localparam int unsigned Prd1W     = 24;
    localparam int unsigned Prd2W     = 18;
    localparam int unsigned Prd3W     = 10;
    localparam int unsigned Prd4W     = 20;
    localparam int unsigned S2Lsb     = Prd1W;
    localparam int unsigned S3Lsb     = S2Lsb + Prd2W;
    localparam int unsigned S4Lsb     = S3Lsb + 2 * Prd3W;

    logic [NumStages-1:0]      v_q, v_d;
    logic [Prd2W-1:0]          d2_q, d2_d;
    logic [1:0][2*Prd3W-1:0]   d3_q, d3_d;
    logic [2:0][2*Prd4W-1:0]   d4_q, d4_d;

    logic kill;
    logic stall;
    logic adv;
    logic accept;

    // Reset behaves like a flush for the handshake and enable gating.
    assign kill   = clear_i | rst_i;
    assign stall  = v_q[NumStages-1] & ~out_ready_i;
    assign adv    = ~stall & ~kill;
    assign accept = in_valid_i & rnd_valid_i & adv;

    assign in_ready_o  = rnd_valid_i & adv;
    assign rnd_ready_o = in_valid_i & adv;
    assign we_o        = {v_q[2:0] & {3{adv}}, accept};
    assign out_valid_o = v_q[NumStages-1];
    assign busy_o      = |v_q;

    // Each slice is only driven on its stage's enable cycle so bubbles never toggle the inverter.
    assign prd_stage1_o  = accept  ? rnd_i[Prd1W-1:0]  : '0;
    assign prd_stage2_o  = we_o[1] ? d2_q              : '0;
    assign prd_stage3a_o = we_o[2] ? d3_q[1][Prd3W-1:0]       : '0;
    assign prd_stage3b_o = we_o[2] ? d3_q[1][2*Prd3W-1:Prd3W] : '0;
    assign prd_stage4a_o = we_o[3] ? d4_q[2][Prd4W-1:0]       : '0;
    assign prd_stage4b_o = we_o[3] ? d4_q[2][2*Prd4W-1:Prd4W] : '0;

    // Next occupancy and delay-line contents; bubbles load zeros, stalls hold.
    always_comb begin
        v_d  = v_q;
        d2_d = d2_q;
        d3_d = d3_q;
        d4_d = d4_q;
        if (clear_i) begin
            v_d  = '0;
            d2_d = '0;
            d3_d = '0;
            d4_d = '0;
        end else if (!stall) begin
            v_d  = {v_q[NumStages-2:0], accept};
            d2_d = accept ? rnd_i[S3Lsb-1:S2Lsb] : '0;
            d3_d = {d3_q[0], (accept ? rnd_i[S4Lsb-1:S3Lsb] : (2*Prd3W)'(0))};
            d4_d = {d4_q[1:0], (accept ? rnd_i[RndWidth-1:S4Lsb] : (2*Prd4W)'(0))};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q  <= '0;
            d2_q <= '0;
            d3_q <= '0;
            d4_q <= '0;
        end else begin
            v_q  <= v_d;
            d2_q <= d2_d;
            d3_q <= d3_d;
            d4_q <= d4_d;
        end
    end

endmodule
